// File: rtl/ncc_desc_builder_pkg.sv
// Shared fixed-point format constants, FSM state type and width helpers
// for the NCC descriptor builder.
package ncc_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int FRAC_W_DEF = 27;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_MEAN,
    ST_SUB,
    ST_HOLD
  } state_t;

  function automatic int out_w(input int pix_w, input int frac_w);
    return pix_w + 1 + frac_w;
  endfunction

  function automatic int sum_w(input int pix_w, input int desc_len);
    return pix_w + $clog2(desc_len);
  endfunction

  // Square of one zero-mean pixel after dropping FRAC_W fractional bits.
  function automatic int sq_w(input int pix_w, input int frac_w);
    return 2 * (pix_w + 1) + frac_w;
  endfunction

  function automatic int energy_w(input int pix_w, input int desc_len, input int frac_w);
    return 2 * (pix_w + 1) + $clog2(desc_len) + frac_w;
  endfunction

endpackage

// File: rtl/ncc_desc_sub_lane.sv
// One pixel lane: (pix << FRAC_W) - mean, plus its truncated square when
// NCC_DESC_ENERGY_EN is defined.
module ncc_desc_sub_lane
  import ncc_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic [PIX_W-1:0]                      pix,
  input  logic [PIX_W+FRAC_W-1:0]               mean,
  output logic signed [out_w(PIX_W, FRAC_W)-1:0] diff
`ifdef NCC_DESC_ENERGY_EN
  ,
  output logic [sq_w(PIX_W, FRAC_W)-1:0]        sq
`endif
);

  localparam int OUT_W = out_w(PIX_W, FRAC_W);

  // Both operands are non-negative and below 2^(PIX_W+FRAC_W), so the
  // OUT_W-bit two's-complement difference never overflows.
  assign diff = {1'b0, pix, {FRAC_W{1'b0}}} - {1'b0, mean};

`ifdef NCC_DESC_ENERGY_EN
  logic signed [2*OUT_W-1:0] prod;

  assign prod = diff * diff;
  assign sq   = sq_w(PIX_W, FRAC_W)'(prod >> FRAC_W);
`endif

endmodule

// File: rtl/ncc_desc_builder.sv
// Buffers one DESC_LEN-pixel descriptor and emits it zero-mean in signed
// fixed point. Optional desc_energy output under NCC_DESC_ENERGY_EN.
//
// state   | meaning
// LOAD    | accept pixel words, accumulate pixel sum
// MEAN    | one cycle: mean = (sum << FRAC_W) >> log2(DESC_LEN)
// SUB     | one word of pixels per cycle minus mean into output regs
// HOLD    | desc_valid high until desc_consume
module ncc_desc_builder
  import ncc_pkg::*;
#(
  parameter int PIX_W        = PIX_W_DEF,
  parameter int PIX_PER_WORD = 4,
  parameter int DESC_LEN     = 64,
  parameter int FRAC_W       = FRAC_W_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   desc_data_valid,
  output logic                                   desc_data_ready,
  input  logic [PIX_PER_WORD*PIX_W-1:0]          desc_data_in,
  input  logic                                   desc_consume,
  output logic                                   desc_valid,
  output logic signed [out_w(PIX_W, FRAC_W)-1:0] descPixelOut [DESC_LEN]
`ifdef NCC_DESC_ENERGY_EN
  ,
  output logic [energy_w(PIX_W, DESC_LEN, FRAC_W)-1:0] desc_energy
`endif
);

  localparam int OUT_W     = out_w(PIX_W, FRAC_W);
  localparam int SUM_W     = sum_w(PIX_W, DESC_LEN);
  localparam int MEAN_W    = PIX_W + FRAC_W;
  localparam int LOG2_LEN  = $clog2(DESC_LEN);
  localparam int N_WORDS   = DESC_LEN / PIX_PER_WORD;
  localparam int CNT_W     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

  state_t              state;
  logic [CNT_W-1:0]    word_idx;
  logic [SUM_W-1:0]    sum;
  logic [MEAN_W-1:0]   mean;
  logic [PIX_W-1:0]    pix_buf   [DESC_LEN];
  logic [PIX_W-1:0]    lane_pix  [PIX_PER_WORD];
  logic [SUM_W-1:0]    psum      [PIX_PER_WORD+1];
  logic signed [OUT_W-1:0] lane_diff [PIX_PER_WORD];
  logic                buf_shift;

`ifdef NCC_DESC_ENERGY_EN
  localparam int SQ_W     = sq_w(PIX_W, FRAC_W);
  localparam int ENERGY_W = energy_w(PIX_W, DESC_LEN, FRAC_W);
  logic [SQ_W-1:0]     lane_sq [PIX_PER_WORD];
  logic [ENERGY_W-1:0] esum    [PIX_PER_WORD+1];
  assign esum[0] = '0;
`endif

  assign psum[0]   = '0;
  assign buf_shift = (state == ST_LOAD && desc_data_valid) || (state == ST_SUB);

  // The raw buffer is a word-wide shift register: words enter at the top
  // during LOAD, and during SUB the lanes always read the bottom word.
  for (genvar j = 0; j < PIX_PER_WORD; j++) begin : g_lane
    assign lane_pix[j] = desc_data_in[(PIX_PER_WORD-1-j)*PIX_W +: PIX_W];
    assign psum[j+1]   = psum[j] + SUM_W'(lane_pix[j]);

    ncc_desc_sub_lane #(
      .PIX_W  (PIX_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .pix  (pix_buf[j]),
      .mean (mean),
      .diff (lane_diff[j])
`ifdef NCC_DESC_ENERGY_EN
      ,
      .sq   (lane_sq[j])
`endif
    );

`ifdef NCC_DESC_ENERGY_EN
    assign esum[j+1] = esum[j] + ENERGY_W'(lane_sq[j]);
`endif
  end

  for (genvar p = 0; p < DESC_LEN; p++) begin : g_pix
    localparam logic [CNT_W-1:0] P_WORD = CNT_W'(p / PIX_PER_WORD);

    if (p < DESC_LEN - PIX_PER_WORD) begin : g_mid
      always_ff @(posedge clk) begin
        if (rst)            pix_buf[p] <= '0;
        else if (buf_shift) pix_buf[p] <= pix_buf[p+PIX_PER_WORD];
      end
    end else begin : g_top
      always_ff @(posedge clk) begin
        if (rst)            pix_buf[p] <= '0;
        else if (buf_shift) pix_buf[p] <= lane_pix[p-(DESC_LEN-PIX_PER_WORD)];
      end
    end

    always_ff @(posedge clk) begin
      if (rst)
        descPixelOut[p] <= '0;
      else if (state == ST_SUB && word_idx == P_WORD)
        descPixelOut[p] <= lane_diff[p % PIX_PER_WORD];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_LOAD;
      word_idx        <= '0;
      sum             <= '0;
      mean            <= '0;
      desc_valid      <= 1'b0;
      desc_data_ready <= 1'b1;
`ifdef NCC_DESC_ENERGY_EN
      desc_energy     <= '0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          if (desc_data_valid) begin
            sum <= sum + psum[PIX_PER_WORD];
            if (word_idx == LAST_WORD) begin
              word_idx        <= '0;
              desc_data_ready <= 1'b0;
              state           <= ST_MEAN;
            end else begin
              word_idx <= word_idx + 1'b1;
            end
          end
        end
        ST_MEAN: begin
          mean  <= MEAN_W'({sum, {FRAC_W{1'b0}}} >> LOG2_LEN);
          state <= ST_SUB;
`ifdef NCC_DESC_ENERGY_EN
          desc_energy <= '0;
`endif
        end
        ST_SUB: begin
`ifdef NCC_DESC_ENERGY_EN
          desc_energy <= desc_energy + esum[PIX_PER_WORD];
`endif
          if (word_idx == LAST_WORD) begin
            word_idx   <= '0;
            desc_valid <= 1'b1;
            state      <= ST_HOLD;
          end else begin
            word_idx <= word_idx + 1'b1;
          end
        end
        ST_HOLD: begin
          if (desc_consume) begin
            desc_valid      <= 1'b0;
            desc_data_ready <= 1'b1;
            sum             <= '0;
            state           <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ncc_desc_builder.sv
// Directed bench for ncc_desc_builder: default instance plus a
// DESC_LEN=16 / PIX_PER_WORD=2 instance; checks energy under NCC_DESC_ENERGY_EN.
module tb_ncc_desc_builder;

  localparam int     OUT_W = 36;
  localparam longint Q     = 64'sd134217728;  // 2^27

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic                    desc_data_valid, desc_data_ready, desc_consume, desc_valid;
  logic [31:0]             desc_data_in;
  logic signed [OUT_W-1:0] dout [64];

  // DESC_LEN=16, PIX_PER_WORD=2 instance
  logic                    v2, ready2, c2, valid2;
  logic [15:0]             d2;
  logic signed [OUT_W-1:0] dout2 [16];

`ifdef NCC_DESC_ENERGY_EN
  logic [50:0] energy;
  logic [48:0] energy2;
`endif

  ncc_desc_builder u_dut (
    .clk             (clk),
    .rst             (rst),
    .desc_data_valid (desc_data_valid),
    .desc_data_ready (desc_data_ready),
    .desc_data_in    (desc_data_in),
    .desc_consume    (desc_consume),
    .desc_valid      (desc_valid),
    .descPixelOut    (dout)
`ifdef NCC_DESC_ENERGY_EN
    ,
    .desc_energy     (energy)
`endif
  );

  ncc_desc_builder #(
    .PIX_PER_WORD (2),
    .DESC_LEN     (16)
  ) u_dut16 (
    .clk             (clk),
    .rst             (rst),
    .desc_data_valid (v2),
    .desc_data_ready (ready2),
    .desc_data_in    (d2),
    .desc_consume    (c2),
    .desc_valid      (valid2),
    .descPixelOut    (dout2)
`ifdef NCC_DESC_ENERGY_EN
    ,
    .desc_energy     (energy2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int kind, input int k);
    case (kind)
      0:       return 32'h05050505;
      1:       return {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  // Called just after a negedge; returns the cycle in which the word is taken.
  task automatic send_word(input logic [31:0] w, output int acc);
    int g = 0;
    desc_data_valid = 1'b1;
    desc_data_in    = w;
    while (!desc_data_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!desc_data_ready) check("send_timeout", 0, 1);
    acc = cyc;
    @(negedge clk);
    desc_data_valid = 1'b0;
  endtask

  task automatic send_desc(input int kind, input bit gap, input bit mid_consume, output int acc);
    for (int k = 0; k < 16; k++) begin
      desc_consume = mid_consume && (k == 8);
      send_word(word_of(kind, k), acc);
      desc_consume = 1'b0;
      if (gap) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input string tag, input int acc, input int lat);
    int g = 0;
    while (!desc_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    check(tag, cyc - acc, lat);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 64; i++) check(tag, dout[i], 0);
  endtask

  task automatic check_ramp(input string tag);
    check({tag, "_out0"},  dout[0],  -64'sd4227858432);
    check({tag, "_out63"}, dout[63],  64'sd4227858432);
    check({tag, "_out32"}, dout[32],  64'sd67108864);
    for (int i = 0; i < 64; i++) check(tag, dout[i], (2*i - 63) * (Q / 2));
`ifdef NCC_DESC_ENERGY_EN
    check({tag, "_energy"}, energy, 21840 * Q);
`endif
  endtask

  task automatic consume_and_check(input string tag);
    desc_consume = 1'b1;
    @(negedge clk);
    desc_consume = 1'b0;
    check({tag, "_valid_drop"}, desc_valid, 0);
    check({tag, "_ready_rise"}, desc_data_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int g;
    rst             = 1'b1;
    desc_data_valid = 1'b0;
    desc_data_in    = '0;
    desc_consume    = 1'b0;
    v2 = 1'b0; d2 = '0; c2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_ready",  desc_data_ready, 1);
    check("rst_valid",  desc_valid, 0);
    check("rst_out0",   dout[0], 0);
    check("rst_out63",  dout[63], 0);
    check("rst_ready2", ready2, 1);
    check("rst_valid2", valid2, 0);

    // constant descriptor, back-to-back
    send_desc(0, 1'b0, 1'b0, acc);
    wait_valid("lat_const", acc, 18);
    check_zero("const_out");
`ifdef NCC_DESC_ENERGY_EN
    check("const_energy", energy, 0);
`endif
    consume_and_check("const");

    // ramp, back-to-back
    send_desc(1, 1'b0, 1'b0, acc);
    wait_valid("lat_ramp", acc, 18);
    check_ramp("ramp");

    // backpressure in HOLD
    desc_data_valid = 1'b1;
    desc_data_in    = 32'hAAAAAAAA;
    check("hold_ready", desc_data_ready, 0);
    repeat (3) @(negedge clk);
    check("hold_ready_late", desc_data_ready, 0);
    check("hold_valid", desc_valid, 1);
    check("hold_out0", dout[0], -64'sd4227858432);
    desc_data_valid = 1'b0;
    consume_and_check("bp");

    // all-255 descriptor with a stray consume during LOAD
    send_desc(2, 1'b0, 1'b1, acc);
    wait_valid("lat_255", acc, 18);
    check_zero("ff_out");
    consume_and_check("ff");

    // gapped ramp
    send_desc(1, 1'b1, 1'b0, acc);
    wait_valid("lat_gap", acc, 18);
    check_ramp("gap");
    consume_and_check("gap");

    // reset mid-load after 7 words of 255
    for (int k = 0; k < 7; k++) send_word(32'hFFFFFFFF, acc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", desc_data_ready, 1);
    check("midrst_valid", desc_valid, 0);
    send_desc(0, 1'b0, 1'b0, acc);
    wait_valid("lat_midrst", acc, 18);
    check_zero("midrst_out");
    consume_and_check("midrst");

    // DESC_LEN=16, PIX_PER_WORD=2 ramp
    for (int k = 0; k < 8; k++) begin
      v2 = 1'b1;
      d2 = {8'(2*k), 8'(2*k+1)};
      check("p16_ready", ready2, 1);
      acc = cyc;
      @(negedge clk);
    end
    v2 = 1'b0;
    g = 0;
    while (!valid2 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("lat_p16", cyc - acc, 10);
    check("p16_out0",  dout2[0],  -64'sd1006632960);
    check("p16_out15", dout2[15],  64'sd1006632960);
    check("p16_out7",  dout2[7],  -64'sd67108864);
    check("p16_out8",  dout2[8],   64'sd67108864);
`ifdef NCC_DESC_ENERGY_EN
    check("p16_energy", energy2, 340 * Q);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
